// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: a two-entry FIFO (head plus skid) between decode and
// execute. It forwards operands from EX/MEM and MEM/WB into the head entry and
// snoops MEM/WB writebacks into stored register data, so a stalled
// instruction never carries a stale operand.
module id_ex_stage #(
    parameter int N_BITS = 32,
    parameter int N_REGS = 32,
    localparam int N_IDX = $clog2(N_REGS)
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              id_valid,
    output logic              id_ready,
    input  logic [3:0]        id_alu_op,
    input  logic [N_IDX-1:0]  id_rs1_idx,
    input  logic [N_IDX-1:0]  id_rs2_idx,
    input  logic [N_IDX-1:0]  id_rd_idx,
    input  logic [N_BITS-1:0] id_rs1_data,
    input  logic [N_BITS-1:0] id_rs2_data,
    input  logic [N_BITS-1:0] id_imm,
    input  logic [N_BITS-1:0] id_pc,
    input  logic              id_use_imm,
    input  logic              id_use_pc,
    input  logic              id_rd_wen,

    input  logic              flush,

    input  logic              exmem_rd_wen,
    input  logic [N_IDX-1:0]  exmem_rd_idx,
    input  logic [N_BITS-1:0] exmem_rd_data,

    input  logic              memwb_rd_wen,
    input  logic [N_IDX-1:0]  memwb_rd_idx,
    input  logic [N_BITS-1:0] memwb_rd_data,

    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [3:0]        ex_alu_op,
    output logic [N_BITS-1:0] ex_in0,
    output logic [N_BITS-1:0] ex_in1,
    output logic [N_BITS-1:0] ex_rs2_val,
    output logic [N_IDX-1:0]  ex_rd_idx,
    output logic              ex_rd_wen
);

    typedef struct packed {
        logic [3:0]        aluOp;
        logic [N_IDX-1:0]  rs1Idx;
        logic [N_IDX-1:0]  rs2Idx;
        logic [N_IDX-1:0]  rdIdx;
        logic [N_BITS-1:0] rs1Data;
        logic [N_BITS-1:0] rs2Data;
        logic [N_BITS-1:0] imm;
        logic [N_BITS-1:0] pc;
        logic              useImm;
        logic              usePc;
        logic              rdWen;
    } entry_t;

    entry_t            head_q;
    entry_t            head_d;
    entry_t            skid_q;
    entry_t            skid_d;
    entry_t            incoming;
    logic              headValid_q;
    logic              headValid_d;
    logic              skidValid_q;
    logic              skidValid_d;
    logic              enq;
    logic              deq;
    logic [N_BITS-1:0] fwdRs1;
    logic [N_BITS-1:0] fwdRs2;

    // A writeback to a nonzero register replaces any matching stored source value.
    function automatic entry_t applySnoop(
        input entry_t            e,
        input logic              wen,
        input logic [N_IDX-1:0]  idx,
        input logic [N_BITS-1:0] data
    );
        entry_t r;
        r = e;
        if (wen && (idx != '0)) begin
            if (r.rs1Idx == idx) r.rs1Data = data;
            if (r.rs2Idx == idx) r.rs2Data = data;
        end
        return r;
    endfunction

    // The younger producer (EX/MEM) beats MEM/WB; register 0 always uses the stored value.
    function automatic logic [N_BITS-1:0] forwardOperand(
        input logic [N_IDX-1:0]  rsIdx,
        input logic [N_BITS-1:0] stored,
        input logic              exWen,
        input logic [N_IDX-1:0]  exIdx,
        input logic [N_BITS-1:0] exData,
        input logic              wbWen,
        input logic [N_IDX-1:0]  wbIdx,
        input logic [N_BITS-1:0] wbData
    );
        logic [N_BITS-1:0] v;
        v = stored;
        if (rsIdx != '0) begin
            if (exWen && (exIdx == rsIdx)) begin
                v = exData;
            end else if (wbWen && (wbIdx == rsIdx)) begin
                v = wbData;
            end
        end
        return v;
    endfunction

    // id_ready depends only on registered state, so there is no path from ex_ready.
    assign id_ready = !skidValid_q;
    assign ex_valid = headValid_q;
    assign enq      = id_valid && !skidValid_q;
    assign deq      = headValid_q && ex_ready;

    // Pack the incoming instruction, applying this cycle's writeback so it never enqueues stale data.
    always_comb begin
        incoming         = '0;
        incoming.aluOp   = id_alu_op;
        incoming.rs1Idx  = id_rs1_idx;
        incoming.rs2Idx  = id_rs2_idx;
        incoming.rdIdx   = id_rd_idx;
        incoming.rs1Data = id_rs1_data;
        incoming.rs2Data = id_rs2_data;
        incoming.imm     = id_imm;
        incoming.pc      = id_pc;
        incoming.useImm  = id_use_imm;
        incoming.usePc   = id_use_pc;
        incoming.rdWen   = id_rd_wen;
        incoming         = applySnoop(incoming, memwb_rd_wen, memwb_rd_idx, memwb_rd_data);
    end

    // FIFO next state: flush wins, then dequeue promotes skid or bypasses input into head.
    always_comb begin
        head_d      = applySnoop(head_q, memwb_rd_wen, memwb_rd_idx, memwb_rd_data);
        skid_d      = applySnoop(skid_q, memwb_rd_wen, memwb_rd_idx, memwb_rd_data);
        headValid_d = headValid_q;
        skidValid_d = skidValid_q;
        if (flush) begin
            headValid_d = 1'b0;
            skidValid_d = 1'b0;
        end else if (deq) begin
            if (skidValid_q) begin
                head_d      = skid_d;
                headValid_d = 1'b1;
                skidValid_d = 1'b0;
            end else if (enq) begin
                head_d      = incoming;
                headValid_d = 1'b1;
            end else begin
                headValid_d = 1'b0;
            end
        end else if (enq) begin
            if (!headValid_q) begin
                head_d      = incoming;
                headValid_d = 1'b1;
            end else begin
                skid_d      = incoming;
                skidValid_d = 1'b1;
            end
        end
    end

    // Register both entries; reset clears valid bits and payload immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q      <= '0;
            skid_q      <= '0;
            headValid_q <= 1'b0;
            skidValid_q <= 1'b0;
        end else begin
            head_q      <= head_d;
            skid_q      <= skid_d;
            headValid_q <= headValid_d;
            skidValid_q <= skidValid_d;
        end
    end

    // Operand resolution on the head entry.
    always_comb begin
        fwdRs1 = forwardOperand(head_q.rs1Idx, head_q.rs1Data,
                                exmem_rd_wen, exmem_rd_idx, exmem_rd_data,
                                memwb_rd_wen, memwb_rd_idx, memwb_rd_data);
        fwdRs2 = forwardOperand(head_q.rs2Idx, head_q.rs2Data,
                                exmem_rd_wen, exmem_rd_idx, exmem_rd_data,
                                memwb_rd_wen, memwb_rd_idx, memwb_rd_data);
    end

    assign ex_in0     = head_q.usePc  ? head_q.pc  : fwdRs1;
    assign ex_in1     = head_q.useImm ? head_q.imm : fwdRs2;
    assign ex_rs2_val = fwdRs2;
    assign ex_alu_op  = head_q.aluOp;
    assign ex_rd_idx  = head_q.rdIdx;
    assign ex_rd_wen  = head_q.rdWen;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed scenarios followed by random traffic,
// checked against a queue-based model of an in-order two-slot buffer with
// operand forwarding and writeback snooping.
module tb_id_ex_stage;

    localparam int NB = 32;
    localparam int NR = 32;
    localparam int NI = $clog2(NR);

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic          id_ready;
    logic [3:0]    id_alu_op;
    logic [NI-1:0] id_rs1_idx;
    logic [NI-1:0] id_rs2_idx;
    logic [NI-1:0] id_rd_idx;
    logic [NB-1:0] id_rs1_data;
    logic [NB-1:0] id_rs2_data;
    logic [NB-1:0] id_imm;
    logic [NB-1:0] id_pc;
    logic          id_use_imm;
    logic          id_use_pc;
    logic          id_rd_wen;
    logic          flush;
    logic          exmem_rd_wen;
    logic [NI-1:0] exmem_rd_idx;
    logic [NB-1:0] exmem_rd_data;
    logic          memwb_rd_wen;
    logic [NI-1:0] memwb_rd_idx;
    logic [NB-1:0] memwb_rd_data;
    logic          ex_valid;
    logic          ex_ready;
    logic [3:0]    ex_alu_op;
    logic [NB-1:0] ex_in0;
    logic [NB-1:0] ex_in1;
    logic [NB-1:0] ex_rs2_val;
    logic [NI-1:0] ex_rd_idx;
    logic          ex_rd_wen;

    id_ex_stage #(.N_BITS(NB), .N_REGS(NR)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_alu_op     (id_alu_op),
        .id_rs1_idx    (id_rs1_idx),
        .id_rs2_idx    (id_rs2_idx),
        .id_rd_idx     (id_rd_idx),
        .id_rs1_data   (id_rs1_data),
        .id_rs2_data   (id_rs2_data),
        .id_imm        (id_imm),
        .id_pc         (id_pc),
        .id_use_imm    (id_use_imm),
        .id_use_pc     (id_use_pc),
        .id_rd_wen     (id_rd_wen),
        .flush         (flush),
        .exmem_rd_wen  (exmem_rd_wen),
        .exmem_rd_idx  (exmem_rd_idx),
        .exmem_rd_data (exmem_rd_data),
        .memwb_rd_wen  (memwb_rd_wen),
        .memwb_rd_idx  (memwb_rd_idx),
        .memwb_rd_data (memwb_rd_data),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_alu_op     (ex_alu_op),
        .ex_in0        (ex_in0),
        .ex_in1        (ex_in1),
        .ex_rs2_val    (ex_rs2_val),
        .ex_rd_idx     (ex_rd_idx),
        .ex_rd_wen     (ex_rd_wen)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    op;
        logic [NI-1:0] rs1;
        logic [NI-1:0] rs2;
        logic [NI-1:0] rd;
        logic [NB-1:0] d1;
        logic [NB-1:0] d2;
        logic [NB-1:0] imm;
        logic [NB-1:0] pc;
        logic          useImm;
        logic          usePc;
        logic          wen;
    } instT;

    instT          sbQ[$];
    instT          h;
    instT          inc;
    int            occ;
    int            total = 0;
    int            bad = 0;
    logic [NB-1:0] e0;
    logic [NB-1:0] e1;
    logic [NB-1:0] er;

    logic          chkIn0 = 1'b0;
    logic          chkIn1 = 1'b0;
    logic          chkRs2 = 1'b0;
    logic [NB-1:0] expIn0 = '0;
    logic [NB-1:0] expIn1 = '0;
    logic [NB-1:0] expRs2 = '0;

    // Operand the execute stage should see: the newest in-flight producer wins, x0 never forwards.
    function automatic logic [NB-1:0] refOperand(input logic [NI-1:0] idx, input logic [NB-1:0] stored);
        if (idx == 0) return stored;
        if (exmem_rd_wen && exmem_rd_idx == idx) return exmem_rd_data;
        if (memwb_rd_wen && memwb_rd_idx == idx) return memwb_rd_data;
        return stored;
    endfunction

    task automatic checkOutput(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor and model: compare the head against the model, then advance the model by one cycle.
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            sbQ.delete();
            #1;
            checkOutput("rst_ex_valid", 32'(ex_valid), 32'd0);
            checkOutput("rst_id_ready", 32'(id_ready), 32'd1);
            checkOutput("rst_ex_in0", ex_in0, 32'd0);
            checkOutput("rst_ex_in1", ex_in1, 32'd0);
            checkOutput("rst_rs2_val", ex_rs2_val, 32'd0);
            checkOutput("rst_alu_op", 32'(ex_alu_op), 32'd0);
            checkOutput("rst_rd_idx", 32'(ex_rd_idx), 32'd0);
            checkOutput("rst_rd_wen", 32'(ex_rd_wen), 32'd0);
        end else begin
            occ = sbQ.size();
            checkOutput("id_ready", 32'(id_ready), 32'(occ < 2));
            checkOutput("ex_valid", 32'(ex_valid), 32'(occ > 0));
            if (occ > 0) begin
                h  = sbQ[0];
                e0 = h.usePc  ? h.pc  : refOperand(h.rs1, h.d1);
                e1 = h.useImm ? h.imm : refOperand(h.rs2, h.d2);
                er = refOperand(h.rs2, h.d2);
                checkOutput("alu_op", 32'(ex_alu_op), 32'(h.op));
                checkOutput("ex_in0", ex_in0, e0);
                checkOutput("ex_in1", ex_in1, e1);
                checkOutput("rs2_val", ex_rs2_val, er);
                checkOutput("rd_idx", 32'(ex_rd_idx), 32'(h.rd));
                checkOutput("rd_wen", 32'(ex_rd_wen), 32'(h.wen));
                if (ex_ready) sbQ.delete(0);
            end
            if (chkIn0) checkOutput("dir_in0", ex_in0, expIn0);
            if (chkIn1) checkOutput("dir_in1", ex_in1, expIn1);
            if (chkRs2) checkOutput("dir_rs2", ex_rs2_val, expRs2);
            if (memwb_rd_wen && memwb_rd_idx != 0) begin
                foreach (sbQ[i]) begin
                    if (sbQ[i].rs1 == memwb_rd_idx) sbQ[i].d1 = memwb_rd_data;
                    if (sbQ[i].rs2 == memwb_rd_idx) sbQ[i].d2 = memwb_rd_data;
                end
            end
            if (flush) begin
                sbQ.delete();
            end else if (id_valid && occ < 2) begin
                inc.op     = id_alu_op;
                inc.rs1    = id_rs1_idx;
                inc.rs2    = id_rs2_idx;
                inc.rd     = id_rd_idx;
                inc.d1     = id_rs1_data;
                inc.d2     = id_rs2_data;
                inc.imm    = id_imm;
                inc.pc     = id_pc;
                inc.useImm = id_use_imm;
                inc.usePc  = id_use_pc;
                inc.wen    = id_rd_wen;
                if (memwb_rd_wen && memwb_rd_idx != 0) begin
                    if (inc.rs1 == memwb_rd_idx) inc.d1 = memwb_rd_data;
                    if (inc.rs2 == memwb_rd_idx) inc.d2 = memwb_rd_data;
                end
                sbQ.push_back(inc);
            end
        end
    end

    // Advance to just after the next rising edge and return pulsed inputs to idle.
    task automatic nextCycle();
        @(posedge clk);
        #1;
        chkIn0       = 1'b0;
        chkIn1       = 1'b0;
        chkRs2       = 1'b0;
        id_valid     = 1'b0;
        flush        = 1'b0;
        exmem_rd_wen = 1'b0;
        memwb_rd_wen = 1'b0;
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [NI-1:0] rs1, input logic [NI-1:0] rs2,
                                 input logic [NI-1:0] rd, input logic [NB-1:0] d1, input logic [NB-1:0] d2,
                                 input logic [NB-1:0] imm, input logic [NB-1:0] pc,
                                 input logic useImm, input logic usePc, input logic wen);
        id_valid    = 1'b1;
        id_alu_op   = op;
        id_rs1_idx  = rs1;
        id_rs2_idx  = rs2;
        id_rd_idx   = rd;
        id_rs1_data = d1;
        id_rs2_data = d2;
        id_imm      = imm;
        id_pc       = pc;
        id_use_imm  = useImm;
        id_use_pc   = usePc;
        id_rd_wen   = wen;
    endtask

    task automatic setForward(input logic exW, input logic [NI-1:0] exI, input logic [NB-1:0] exD,
                              input logic wbW, input logic [NI-1:0] wbI, input logic [NB-1:0] wbD);
        exmem_rd_wen  = exW;
        exmem_rd_idx  = exI;
        exmem_rd_data = exD;
        memwb_rd_wen  = wbW;
        memwb_rd_idx  = wbI;
        memwb_rd_data = wbD;
    endtask

    logic [3:0] ops [4] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100};

    // Stimulus: directed scenarios, then randomized traffic.
    initial begin
        rst = 1'b1;
        ex_ready = 1'b1;
        id_valid = 1'b0;
        flush = 1'b0;
        applyStimulus(4'h0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        id_valid = 1'b0;
        setForward(1'b0, '0, '0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Back-to-back stream with no backpressure.
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            applyStimulus(ops[i], NI'(1), NI'(2), NI'(i + 3), $urandom, $urandom, $urandom, $urandom,
                          1'b0, 1'b0, 1'b1);
        end
        repeat (3) nextCycle();

        // Backpressure fills both slots, then drains in order.
        ex_ready = 1'b0;
        applyStimulus(4'hA, NI'(8), NI'(9), NI'(10), 32'h1111, 32'h2222, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(4'hB, NI'(11), NI'(12), NI'(13), 32'h3333, 32'h4444, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        repeat (3) nextCycle();
        ex_ready = 1'b1;
        repeat (3) nextCycle();

        // Forwarding priority on rs1.
        flush = 1'b1;
        nextCycle();
        ex_ready = 1'b0;
        applyStimulus(4'h3, NI'(5), NI'(6), NI'(1), 32'h1, 32'h2, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        nextCycle();
        setForward(1'b1, NI'(5), 32'hAA, 1'b1, NI'(5), 32'hBB);
        chkIn0 = 1'b1; expIn0 = 32'hAA;
        nextCycle();
        setForward(1'b0, NI'(5), 32'hAA, 1'b1, NI'(5), 32'hBB);
        chkIn0 = 1'b1; expIn0 = 32'hBB;
        nextCycle();
        flush = 1'b1;
        nextCycle();
        applyStimulus(4'h3, NI'(0), NI'(6), NI'(1), 32'h77, 32'h2, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        nextCycle();
        setForward(1'b1, NI'(0), 32'hAA, 1'b1, NI'(0), 32'hBB);
        chkIn0 = 1'b1; expIn0 = 32'h77;
        nextCycle();

        // Writeback snoop while stalled.
        flush = 1'b1;
        nextCycle();
        applyStimulus(4'h5, NI'(1), NI'(7), NI'(2), 32'h0, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        nextCycle();
        setForward(1'b0, '0, '0, 1'b1, NI'(7), 32'h55);
        chkIn1 = 1'b1; expIn1 = 32'h55; chkRs2 = 1'b1; expRs2 = 32'h55;
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            chkIn1 = 1'b1; expIn1 = 32'h55; chkRs2 = 1'b1; expRs2 = 32'h55;
            if (i == 2) ex_ready = 1'b1;
        end
        nextCycle();

        // Operand select with PC and immediate.
        flush = 1'b1;
        nextCycle();
        ex_ready = 1'b0;
        applyStimulus(4'h6, NI'(2), NI'(3), NI'(4), 32'h5, 32'h1, 32'hFFFFFFFC, 32'h100, 1'b1, 1'b1, 1'b1);
        nextCycle();
        setForward(1'b1, NI'(3), 32'h9, 1'b0, '0, '0);
        chkIn0 = 1'b1; expIn0 = 32'h100;
        chkIn1 = 1'b1; expIn1 = 32'hFFFFFFFC;
        chkRs2 = 1'b1; expRs2 = 32'h9;
        nextCycle();
        ex_ready = 1'b1;
        nextCycle();

        // Flush of a full buffer with a same-cycle enqueue, then reset mid-stall.
        ex_ready = 1'b0;
        applyStimulus(4'h1, NI'(1), NI'(2), NI'(3), 32'hA, 32'hB, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(4'h2, NI'(1), NI'(2), NI'(3), 32'hC, 32'hD, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(4'h7, NI'(1), NI'(2), NI'(3), 32'hE, 32'hF, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        flush = 1'b1;
        nextCycle();
        ex_ready = 1'b1;
        nextCycle();
        ex_ready = 1'b0;
        applyStimulus(4'h8, NI'(4), NI'(5), NI'(6), 32'h12, 32'h34, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(4'h9, NI'(4), NI'(5), NI'(6), 32'h56, 32'h78, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
        nextCycle();
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        nextCycle();
        ex_ready = 1'b1;
        nextCycle();

        // Randomized traffic with small register indices so matches are frequent.
        for (int c = 0; c < 2000; c++) begin
            nextCycle();
            ex_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) != 0)
                applyStimulus(4'($urandom), NI'($urandom_range(0, 7)), NI'($urandom_range(0, 7)),
                              NI'($urandom_range(0, 31)), $urandom, $urandom, $urandom, $urandom,
                              1'($urandom), 1'($urandom), 1'($urandom));
            setForward(1'($urandom), NI'($urandom_range(0, 7)), $urandom,
                       1'($urandom), NI'($urandom_range(0, 7)), $urandom);
            flush = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end

        nextCycle();
        ex_ready = 1'b1;
        repeat (4) nextCycle();
        @(negedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter N_BITS, default 32, datapath width; parameter N_REGS, default 32, register count; N_IDX = $clog2(N_REGS) derived.
REQ-002 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have id_valid input 1 / id_ready output 1: upstream handshake.
REQ-005 SHALL have id_alu_op input 4; id_rs1_idx, id_rs2_idx, id_rd_idx input N_IDX; id_rs1_data, id_rs2_data, id_imm, id_pc input N_BITS; id_use_imm, id_use_pc, id_rd_wen input 1.
REQ-006 SHALL have flush input 1: discard all held instructions.
REQ-007 SHALL have exmem_rd_wen input 1, exmem_rd_idx input N_IDX, exmem_rd_data input N_BITS: EX/MEM forward source.
REQ-008 SHALL have memwb_rd_wen input 1, memwb_rd_idx input N_IDX, memwb_rd_data input N_BITS: MEM/WB forward and writeback source.
REQ-009 SHALL have ex_valid output 1 / ex_ready input 1: downstream handshake.
REQ-010 SHALL have ex_alu_op output 4, ex_in0 and ex_in1 output N_BITS (ALU operands), ex_rs2_val output N_BITS (store data), ex_rd_idx output N_IDX, ex_rd_wen output 1.

Function
REQ-011 SHALL hold a 2-entry FIFO (head + skid); each entry stores all id_* payload fields plus a valid bit.
REQ-012 SHALL accept input when id_valid && id_ready; SHALL retire head when ex_valid && ex_ready.
REQ-013 SHALL drive id_ready = !skid_valid (registered state only, no combinational path from ex_ready).
REQ-014 SHALL drive ex_valid = head_valid; accepted instruction appears on ex_valid the next cycle (latency 1).
REQ-015 SHALL sustain one transfer per cycle when ex_ready=1 continuously.
REQ-016 Simultaneous enqueue and dequeue SHALL keep occupancy unchanged; order strictly FIFO.
REQ-017 Enqueue into empty FIFO, or with head retiring and skid empty, SHALL write head; otherwise skid.
REQ-018 While ex_valid=1 and ex_ready=0, stored fields SHALL remain stable (forwarded operands may still change per REQ-020).
REQ-019 Writeback snoop: each cycle memwb_rd_wen=1 and memwb_rd_idx!=0, every valid entry (and the entry being enqueued) with matching rs1/rs2 idx SHALL update its stored rs data to memwb_rd_data.
REQ-020 Forwarding on head, per operand: exmem match (wen=1, idx!=0, idx==rs) SHALL win; else memwb match; else stored data.
REQ-021 Register index 0 SHALL never be forwarded or snooped; stored value used.
REQ-022 ex_in0 SHALL = head.use_pc ? head.pc : fwd_rs1; ex_in1 SHALL = head.use_imm ? head.imm : fwd_rs2; ex_rs2_val SHALL = fwd_rs2.
REQ-023 ex_alu_op, ex_rd_idx, ex_rd_wen SHALL pass head fields unchanged.
REQ-024 flush=1 SHALL clear both valid bits at the next edge; a same-cycle enqueue SHALL be dropped; id_ready=1 the following cycle.
REQ-025 No arithmetic performed; all widths pass-through, no extension or truncation.

Reset
REQ-026 rst=1 SHALL immediately clear both valid bits and all stored fields to 0 regardless of clk.
REQ-027 During and after reset: ex_valid=0, id_ready=1, ex_in0=ex_in1=ex_rs2_val=0, ex_alu_op=0, ex_rd_idx=0, ex_rd_wen=0.
REQ-028 Reset mid-stall SHALL drop held instructions; no partial transfer.

Verification
REQ-029 Back-to-back: ex_ready=1, 4 instructions on consecutive cycles, alu_op 0000,0001,0010,0100 -> same ops on ex_valid cycles 1-4 after input, id_ready constant 1.
REQ-030 Backpressure: ex_ready=0, enqueue A then B -> id_ready=0 after second accept; release ex_ready -> A then B in order, no loss or duplicate.
REQ-031 Forward priority: head rs1=5, stored 0x1, exmem(5,0xAA,wen=1), memwb(5,0xBB,wen=1) -> ex_in0=0xAA; exmem_wen=0 -> 0xBB; rs1=0 with idx 0 matches -> stored value.
REQ-032 Snoop under stall: head rs2=7 stored 0x10, ex_ready=0, one-cycle memwb(7,0x55) then idle -> ex_in1 and ex_rs2_val=0x55 until retire.
REQ-033 Operand select: use_pc=1 pc=0x100, use_imm=1 imm=0xFFFFFFFC, rs2 forwarded 0x9 -> ex_in0=0x100, ex_in1=0xFFFFFFFC, ex_rs2_val=0x9.
REQ-034 Flush/reset: FIFO full, flush=1 with id_valid=1 -> next cycle ex_valid=0, id_ready=1, flushed-cycle input absent; async rst pulse between edges -> outputs zero immediately.
